// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor (diff = a - b) processing BITS_PER_CYCLE bits per clock, LSB first.
// Optional build macro SERIAL_SUBTRACTOR_SAT_EN clamps underflowing results to zero.
module serial_subtractor #(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bor,
   output logic             zero
);

   localparam int unsigned BPC   = BITS_PER_CYCLE;
   localparam int unsigned N     = WIDTH / BPC;
   localparam int unsigned CTR_W = $clog2(N) + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   if (WIDTH < 2 || BPC == 0 || BPC > WIDTH || (WIDTH % BPC) != 0) begin : g_bad_cfg
      $error("serial_subtractor: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
   end

   logic [1:0]           state;
   logic [1:0]           state_nx;
   logic [WIDTH-1:0]     a_sr;
   logic [WIDTH-1:0]     b_sr;
   logic [WIDTH-1:0]     res_sr;
   logic                 borrow_reg;
   logic [CTR_W-1:0]     ctr;

   logic                 accept_c;
   logic                 last_c;
   logic [BPC-1:0]       slice_x;
   logic [BPC-1:0]       slice_y;
   logic [BPC-1:0]       slice_d;
   logic [BPC:0]         bi;
   logic [WIDTH+BPC-1:0] res_cat;
   logic [WIDTH-1:0]     res_next;

   // Ripple chain of 1-bit subtractor cells for the current slice
   assign slice_x = a_sr[BPC-1:0];
   assign slice_y = b_sr[BPC-1:0];
   assign bi[0]   = borrow_reg;

   for (genvar i = 0; i < BPC; i++) begin : g_cell
      assign slice_d[i] = slice_x[i] ^ slice_y[i] ^ bi[i];
      assign bi[i+1]    = (~slice_x[i] & slice_y[i]) | (~(slice_x[i] ^ slice_y[i]) & bi[i]);
   end

   // Slice result enters from the MSB side, so after N slices bit 0 sits at the bottom
   assign res_cat  = {slice_d, res_sr};
   assign res_next = res_cat[WIDTH+BPC-1:BPC];

   assign accept_c = start && (state == IDLE || state == DONE);
   assign last_c   = (state == RUN) && (ctr == CTR_W'(N - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (ctr == CTR_W'(N - 1)) state_nx = DONE;
         DONE:    state_nx = start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath and registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr       <= '0;
         b_sr       <= '0;
         res_sr     <= '0;
         borrow_reg <= 1'b0;
         ctr        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         bor        <= 1'b0;
         zero       <= 1'b0;
      end else begin
         busy <= (state_nx == RUN);
         done <= (state_nx == DONE);
         if (accept_c) begin
            a_sr       <= a;
            b_sr       <= b;
            res_sr     <= '0;
            borrow_reg <= 1'b0;
            ctr        <= '0;
         end else if (state == RUN) begin
            a_sr       <= a_sr >> BPC;
            b_sr       <= b_sr >> BPC;
            res_sr     <= res_next;
            borrow_reg <= bi[BPC];
            ctr        <= ctr + CTR_W'(1);
            if (last_c) begin
               bor <= bi[BPC];
`ifdef SERIAL_SUBTRACTOR_SAT_EN
               diff <= bi[BPC] ? '0 : res_next;
               zero <= bi[BPC] | (res_next == '0);
`else
               diff <= res_next;
               zero <= (res_next == '0);
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases on an 8x1 instance,
// randomized back-to-back traffic on 8x4 and 8x8 instances, all against a cycle-level model.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       st   [3];
   logic [7:0] av   [3];
   logic [7:0] bv   [3];
   logic       busy_v [3];
   logic       done_v [3];
   logic [7:0] diff_v [3];
   logic       bor_v  [3];
   logic       zero_v [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut0 (
      .clk(clk), .rst(rst), .start(st[0]), .a(av[0]), .b(bv[0]),
      .busy(busy_v[0]), .done(done_v[0]), .diff(diff_v[0]), .bor(bor_v[0]), .zero(zero_v[0]));
   serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut1 (
      .clk(clk), .rst(rst), .start(st[1]), .a(av[1]), .b(bv[1]),
      .busy(busy_v[1]), .done(done_v[1]), .diff(diff_v[1]), .bor(bor_v[1]), .zero(zero_v[1]));
   serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(8)) u_dut2 (
      .clk(clk), .rst(rst), .start(st[2]), .a(av[2]), .b(bv[2]),
      .busy(busy_v[2]), .done(done_v[2]), .diff(diff_v[2]), .bor(bor_v[2]), .zero(zero_v[2]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: an accepted op finishes exactly N edges later with a-b
   int         nsl   [3] = '{8, 2, 1};
   int         left  [3] = '{0, 0, 0};
   int         ndone [3] = '{0, 0, 0};
   logic [7:0] pa [3];
   logic [7:0] pb [3];
   logic       e_busy [3] = '{0, 0, 0};
   logic       e_done [3] = '{0, 0, 0};
   logic [7:0] e_diff [3] = '{0, 0, 0};
   logic       e_bor  [3] = '{0, 0, 0};
   logic       e_zero [3] = '{0, 0, 0};

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            left[i] = 0; e_busy[i] = 0; e_done[i] = 0;
            e_diff[i] = 0; e_bor[i] = 0; e_zero[i] = 0;
         end else begin
            e_done[i] = 0;
            if (left[i] > 0) begin
               left[i]--;
               if (left[i] == 0) begin
                  e_done[i] = 1;
                  ndone[i]++;
                  e_bor[i]  = (pa[i] < pb[i]);
                  e_diff[i] = pa[i] - pb[i];
`ifdef SERIAL_SUBTRACTOR_SAT_EN
                  if (pa[i] < pb[i]) e_diff[i] = 8'h00;
`endif
                  e_zero[i] = (e_diff[i] == 8'h00);
               end
            end else if (st[i]) begin
               pa[i] = av[i];
               pb[i] = bv[i];
               left[i] = nsl[i];
            end
            e_busy[i] = (left[i] > 0);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy%0d", i), 32'(busy_v[i]), 32'(e_busy[i]));
            chk($sformatf("done%0d", i), 32'(done_v[i]), 32'(e_done[i]));
            chk($sformatf("diff%0d", i), 32'(diff_v[i]), 32'(e_diff[i]));
            chk($sformatf("bor%0d", i),  32'(bor_v[i]),  32'(e_bor[i]));
            chk($sformatf("zero%0d", i), 32'(zero_v[i]), 32'(e_zero[i]));
         end
      end
   end

   // Called at a negedge; returns at the negedge of the done cycle (or after the bound)
   task automatic run_op(input logic [7:0] aa, input logic [7:0] bb, input logic [7:0] ed,
                         input logic eb, input logic ez, input string nm);
      int cyc;
      st[0] = 1'b1; av[0] = aa; bv[0] = bb;
      @(negedge clk);
      st[0] = 1'b0;
      cyc = 0;
      while (!done_v[0] && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk({nm, "_latency"}, 32'(cyc), 32'd8);
      chk({nm, "_diff"}, 32'(diff_v[0]), 32'(ed));
      chk({nm, "_bor"},  32'(bor_v[0]),  32'(eb));
      chk({nm, "_zero"}, 32'(zero_v[0]), 32'(ez));
   endtask

   initial begin
      int nd;
      logic [7:0] seen;
      for (int i = 0; i < 3; i++) begin st[i] = 0; av[i] = 0; bv[i] = 0; end
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy_v[0]), 32'd0);
      chk("rst_done", 32'(done_v[0]), 32'd0);
      chk("rst_diff", 32'(diff_v[0]), 32'd0);
      chk("rst_bor",  32'(bor_v[0]),  32'd0);
      chk("rst_zero", 32'(zero_v[0]), 32'd0);
      #2 rst = 1'b0;
      @(negedge clk);

      run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, "t1");
      @(negedge clk);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
      run_op(8'h00, 8'h01, 8'h00, 1'b1, 1'b1, "t2");
`else
      run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, "t2");
`endif
      @(negedge clk);
      run_op(8'h80, 8'h80, 8'h00, 1'b0, 1'b1, "t3a");
      run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, "t3b");
      @(negedge clk);

      // Start pulses while busy must be ignored
      st[0] = 1'b1; av[0] = 8'h20; bv[0] = 8'h05;
      nd = 0; seen = 8'h00;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (done_v[0]) begin nd++; seen = diff_v[0]; end
         st[0] = (c == 2 || c == 4);
         if (c > 1) begin av[0] = 8'hFF; bv[0] = 8'h00; end
      end
      chk("t4_done_count", 32'(nd), 32'd1);
      chk("t4_diff", 32'(seen), 32'h1B);

      // Asynchronous reset mid-operation
      st[0] = 1'b1; av[0] = 8'h77; bv[0] = 8'h11;
      @(negedge clk);
      st[0] = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t5_busy", 32'(busy_v[0]), 32'd0);
      chk("t5_done", 32'(done_v[0]), 32'd0);
      chk("t5_diff", 32'(diff_v[0]), 32'd0);
      chk("t5_bor",  32'(bor_v[0]),  32'd0);
      chk("t5_zero", 32'(zero_v[0]), 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      nd = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done_v[0]) nd++;
      end
      chk("t5_no_done", 32'(nd), 32'd0);
      run_op(8'h09, 8'h03, 8'h06, 1'b0, 1'b0, "t5b");
      @(negedge clk);

      // Random traffic on the 4- and 8-bit-per-cycle instances
      for (int c = 0; c < 20000 && (ndone[1] < 1000 || ndone[2] < 1000); c++) begin
         @(negedge clk);
         for (int i = 1; i < 3; i++) begin
            st[i] = ($urandom_range(0, 3) != 0);
            av[i] = 8'($urandom);
            bv[i] = 8'($urandom);
         end
      end
      st[1] = 1'b0; st[2] = 1'b0;
      chk("t6_ops_bpc4", 32'(ndone[1] >= 1000), 32'd1);
      chk("t6_ops_bpc8", 32'(ndone[2] >= 1000), 32'd1);
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
